writeback_stage: RTL and testbench
==================================

# writeback_stage

Parametrised writeback stage for the pipelined RISC-V core. It owns the MEM/WB pipeline register, load-data lane extraction and sign/zero extension, and a four-source result select. It also arbitrates the single register-file write port between in-order pipeline results and late results from a multi-cycle unit (divider) through a one-entry pending buffer, and counts retired instructions.

## Interface
- DATA_WIDTH, 32, datapath width; legal values 32 or 64.
- REG_ADDR_WIDTH, 5, register index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ValidM, RegWriteM  in  1 each  instruction valid / writes rd.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- Funct3M  in  3  load size/sign.
- RdM  in  REG_ADDR_WIDTH  destination register.
- ALUResultM, ReadDataM, PCPlus4M, ImmExtM  in  DATA_WIDTH each  M-stage values; ALUResultM is also the load address.
- StallW, FlushW  in  1 each  hazard-unit controls.
- LateValid  in  1  late result offered.
- LateRd  in  REG_ADDR_WIDTH  late destination.
- LateData  in  DATA_WIDTH  late result.
- LateReady  out  1  late result accepted this cycle (LateValid && LateReady).
- RegWriteW  out  1  register-file write enable.
- RdW  out  REG_ADDR_WIDTH  write address.
- ResultW  out  DATA_WIDTH  write data.
- PendValid  out  1  pending buffer occupied.
- PendRd  out  REG_ADDR_WIDTH  rd held in the buffer, for hazard stalls.
- InstretW  out  64  retired-instruction count.

## Operation
- MEM/WB register update priority: rst > FlushW > StallW > load.
  - rst or FlushW clears all fields (ValidW=0, RegWriteW_p=0).
  - StallW holds the current contents.
  - Otherwise the register captures the M inputs.
- Load extraction uses OFF = log2(DATA_WIDTH/8) address bits.
  - Byte lane: addr[OFF-1:0]. Half lane: addr[OFF-1:1]. Word lane (64 only): addr[2].
  - Low address bits below the access size are ignored; there is no misalignment trap.
  - Funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 64-bit builds add 011 LD and 110 LWU. LW sign-extends in 64-bit builds.
  - Any other funct3, and 011/110 in 32-bit builds, returns the full ReadData.
- Result select uses ResultSrc: 00 ALUResult, 01 extended load, 10 PCPlus4, 11 ImmExt.
- Write port, evaluated each cycle:
  - Pipeline write: RegWriteW_p && RdW_p != 0 → RegWriteW=1, RdW=RdW_p, ResultW=selected result.
  - Otherwise, if PendValid: write PendRd/PendData and clear PendValid at the edge.
  - Otherwise RegWriteW=0. RdW and ResultW then show the pipeline values.
- Pending buffer:
  - LateReady = !PendValid.
  - On LateValid && LateReady, capture LateRd/LateData and set PendValid at the edge.
  - A late result with LateRd=0 is accepted and dropped at drain, with no write.
- The pending buffer drains only in cycles with no pipeline write. During a stall with a writing instruction the pipeline write repeats every cycle and the buffer waits. Preventing starvation is the hazard unit's job.
- Instret increments by 1 on each edge where ValidW && !StallW && !rst. Writes to x0 still retire.

## Timing
- Reset values: all MEM/WB fields 0, RegWriteW=0, RdW=0, ResultW=0, PendValid=0, PendRd=0, LateReady=1, InstretW=0.
- Latency, pipeline path: M inputs captured at edge t; write-port outputs are valid in cycle t+1 (combinational from the W register); the register file commits at edge t+2.
- Latency, late path: accepted at edge t; earliest write in cycle t+1. After accept, LateReady stays low until the edge where the drain completes.
- Accept and drain cannot occur in the same cycle, so buffer throughput is at most one late result per two cycles.
- Reset mid-operation discards any buffered late result; the multi-cycle unit is reset alongside.
- FlushW and StallW in the same cycle: the flush wins, so the next cycle is a bubble and Instret does not increment for it.

## Test plan
- Reset: hold rst 2 cycles with traffic on every input → RegWriteW=0, PendValid=0, LateReady=1, InstretW=0.
- Loads, 32-bit: ReadData 0x80FF1234.
  - addr 0x1003: LB → 0xFFFFFF80; LBU → 0x00000080.
  - addr 0x1002: LH → 0xFFFF80FF; LHU → 0x000080FF.
  - addr 0x1000: funct3 111 → 0x80FF1234.
- Loads, 64-bit: ReadData 0x8000000112345678.
  - addr 0x...4: LW → 0xFFFFFFFF80000001; LWU → 0x0000000080000001.
  - LD → full value.
- Late collision: LateValid at t with x7/0xDEADBEEF; pipeline writes x5 in cycles t+1 and t+2.
  - Required: x5 written t+1 and t+2, x7 written t+3.
  - PendRd=7 and LateReady=0 from t+1 through t+3.
- Stall/flush: a writing instruction is held 3 cycles by StallW → 3 identical writes and no Instret change; on release Instret +1. StallW+FlushW together → bubble next cycle.
- x0 handling: RegWriteM=1 with RdM=0 → RegWriteW=0 and Instret +1. Late result to x0 → LateReady drops for one cycle, no write.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, load extraction, result select,
// and register-file write-port arbitration with a late-result buffer.
module writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ValidM,
  input  logic                      RegWriteM,
  input  logic [1:0]                ResultSrcM,
  input  logic [2:0]                Funct3M,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [DATA_WIDTH-1:0]     ReadDataM,
  input  logic [DATA_WIDTH-1:0]     PCPlus4M,
  input  logic [DATA_WIDTH-1:0]     ImmExtM,
  input  logic                      StallW,
  input  logic                      FlushW,
  input  logic                      LateValid,
  input  logic [REG_ADDR_WIDTH-1:0] LateRd,
  input  logic [DATA_WIDTH-1:0]     LateData,
  output logic                      LateReady,
  output logic                      RegWriteW,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]     ResultW,
  output logic                      PendValid,
  output logic [REG_ADDR_WIDTH-1:0] PendRd,
  output logic [63:0]               InstretW
);

  localparam int DW   = DATA_WIDTH;
  localparam int AW   = REG_ADDR_WIDTH;
  localparam int OFF  = $clog2(DW / 8);
  localparam bit IS64 = (DW == 64);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [1:0]    src;
    logic [2:0]    funct3;
    logic [AW-1:0] rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdata;
    logic [DW-1:0] pc4;
    logic [DW-1:0] imm;
  } mw_t;

  mw_t m;
  mw_t w;

  assign m = '{
    valid:    ValidM,
    regwrite: RegWriteM,
    src:      ResultSrcM,
    funct3:   Funct3M,
    rd:       RdM,
    alu:      ALUResultM,
    rdata:    ReadDataM,
    pc4:      PCPlus4M,
    imm:      ImmExtM
  };

  always_ff @(posedge clk) begin
    if (rst || FlushW) begin
      w <= '0;
    end else if (!StallW) begin
      w <= m;
    end
  end

  logic [OFF-1:0] lane;
  logic [DW-1:0]  bsh;
  logic [DW-1:0]  hsh;
  logic [DW-1:0]  wsh;
  logic [7:0]     lb;
  logic [15:0]    lh;
  logic [31:0]    lw;
  logic [DW-1:0]  ld;

  assign lane = w.alu[OFF-1:0];
  assign bsh  = w.rdata >> {lane, 3'b000};
  assign hsh  = w.rdata >> {lane[OFF-1:1], 4'b0000};
  // The word lane only exists in 64-bit builds.
  assign wsh  = IS64 ? (w.rdata >> {lane[OFF-1], 5'b00000})
                     : w.rdata;
  assign lb   = bsh[7:0];
  assign lh   = hsh[15:0];
  assign lw   = wsh[31:0];

  always_comb begin
    ld = w.rdata;
    unique case (1'b1)
      w.funct3 == 3'b000: ld = DW'($signed(lb));
      w.funct3 == 3'b001: ld = DW'($signed(lh));
      w.funct3 == 3'b010: ld = DW'($signed(lw));
      w.funct3 == 3'b100: ld = DW'(lb);
      w.funct3 == 3'b101: ld = DW'(lh);
      IS64 && w.funct3 == 3'b110: ld = DW'(lw);
      default: ld = w.rdata;
    endcase
  end

  logic [DW-1:0] res;

  always_comb begin
    res = w.alu;
    unique case (w.src)
      2'b00:   res = w.alu;
      2'b01:   res = ld;
      2'b10:   res = w.pc4;
      default: res = w.imm;
    endcase
  end

  logic          pend_valid;
  logic [AW-1:0] pend_rd;
  logic [DW-1:0] pend_data;
  logic          pipe_wr;
  logic          drain;

  assign pipe_wr = w.regwrite && (w.rd != '0);
  assign drain   = !pipe_wr && pend_valid;

  always_comb begin
    RegWriteW = pipe_wr;
    RdW       = w.rd;
    ResultW   = res;
    if (drain && pend_rd != '0) begin
      RegWriteW = 1'b1;
      RdW       = pend_rd;
      ResultW   = pend_data;
    end
  end

  assign LateReady = !pend_valid;
  assign PendValid = pend_valid;
  assign PendRd    = pend_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      pend_data  <= '0;
    end else if (LateValid && !pend_valid) begin
      pend_valid <= 1'b1;
      pend_rd    <= LateRd;
      pend_data  <= LateData;
    end else if (drain) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      InstretW <= '0;
    end else if (w.valid && !StallW) begin
      InstretW <= InstretW + 64'd1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios on 32/64-bit builds
// plus a randomized run against a queue-based reference model.
module tb_writeback_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ValidM, RegWriteM, StallW, FlushW, LateValid;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM, LateRd;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM, LateData;
  logic        LateReady, RegWriteW, PendValid;
  logic [4:0]  RdW, PendRd;
  logic [31:0] ResultW;
  logic [63:0] InstretW;

  logic        q_ValidM, q_RegWriteM, q_StallW, q_FlushW, q_LateValid;
  logic [1:0]  q_ResultSrcM;
  logic [2:0]  q_Funct3M;
  logic [4:0]  q_RdM, q_LateRd;
  logic [63:0] q_ALUResultM, q_ReadDataM, q_PCPlus4M, q_ImmExtM;
  logic [63:0] q_LateData;
  logic        q_LateReady, q_RegWriteW, q_PendValid;
  logic [4:0]  q_RdW, q_PendRd;
  logic [63:0] q_ResultW, q_InstretW;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .StallW(StallW), .FlushW(FlushW),
    .LateValid(LateValid), .LateRd(LateRd), .LateData(LateData),
    .LateReady(LateReady), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .PendValid(PendValid), .PendRd(PendRd),
    .InstretW(InstretW)
  );

  writeback_stage #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst),
    .ValidM(q_ValidM), .RegWriteM(q_RegWriteM),
    .ResultSrcM(q_ResultSrcM), .Funct3M(q_Funct3M), .RdM(q_RdM),
    .ALUResultM(q_ALUResultM), .ReadDataM(q_ReadDataM),
    .PCPlus4M(q_PCPlus4M), .ImmExtM(q_ImmExtM),
    .StallW(q_StallW), .FlushW(q_FlushW),
    .LateValid(q_LateValid), .LateRd(q_LateRd), .LateData(q_LateData),
    .LateReady(q_LateReady), .RegWriteW(q_RegWriteW), .RdW(q_RdW),
    .ResultW(q_ResultW), .PendValid(q_PendValid), .PendRd(q_PendRd),
    .InstretW(q_InstretW)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } late_t;

  function automatic logic [63:0] exp_load(input int dw,
      input logic [63:0] addr, input logic [63:0] rdv,
      input logic [2:0] f3);
    int nb, bo;
    logic [63:0] mask, bv, hv, wv, r;
    nb   = dw / 8;
    bo   = int'(addr[2:0]) % nb;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    bv   = (rdv >> (8 * bo)) & 64'hFF;
    hv   = (rdv >> (16 * (bo / 2))) & 64'hFFFF;
    wv   = (rdv >> (32 * (bo / 4))) & 64'hFFFF_FFFF;
    case (f3)
      3'd0:    r = bv[7] ? (bv | ~64'hFF) : bv;
      3'd1:    r = hv[15] ? (hv | ~64'hFFFF) : hv;
      3'd2:    r = wv[31] ? (wv | ~64'hFFFF_FFFF) : wv;
      3'd4:    r = bv;
      3'd5:    r = hv;
      3'd6:    r = (dw == 64) ? wv : rdv;
      default: r = rdv;
    endcase
    return r & mask;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ValidM = 0; RegWriteM = 0; ResultSrcM = 0; Funct3M = 0; RdM = 0;
    ALUResultM = 0; ReadDataM = 0; PCPlus4M = 0; ImmExtM = 0;
    StallW = 0; FlushW = 0; LateValid = 0; LateRd = 0; LateData = 0;
    q_ValidM = 0; q_RegWriteM = 0; q_ResultSrcM = 0; q_Funct3M = 0;
    q_RdM = 0; q_ALUResultM = 0; q_ReadDataM = 0; q_PCPlus4M = 0;
    q_ImmExtM = 0; q_StallW = 0; q_FlushW = 0; q_LateValid = 0;
    q_LateRd = 0; q_LateData = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] v);
    ValidM = 1; RegWriteM = 1; RdM = rd;
    ResultSrcM = 2'b00; ALUResultM = v;
  endtask

  task automatic test_reset;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      ValidM = 1; RegWriteM = 1; RdM = 5'($urandom_range(1, 31));
      ResultSrcM = 2'($urandom); Funct3M = 3'($urandom);
      ALUResultM = $urandom; ReadDataM = $urandom;
      PCPlus4M = $urandom; ImmExtM = $urandom;
      LateValid = 1; LateRd = 5'($urandom_range(1, 31));
      LateData = $urandom; StallW = 0; FlushW = 0;
      q_ValidM = 1; q_RegWriteM = 1; q_RdM = 5'd3;
      q_ALUResultM = {$urandom, $urandom}; q_LateValid = 1;
      cyc();
    end
    checks++;
    if ({RegWriteW, PendValid, LateReady} !== 3'b001) begin
      failures++;
      $display("FAIL reset_flags got=%b want=001",
               {RegWriteW, PendValid, LateReady});
    end
    checks++;
    if (InstretW !== 64'd0 || q_InstretW !== 64'd0) begin
      failures++;
      $display("FAIL reset_instret got=%0d/%0d want=0",
               InstretW, q_InstretW);
    end
    checks++;
    if ({RdW, ResultW, PendRd} !== '0) begin
      failures++;
      $display("FAIL reset_outs rd=%0d res=%h prd=%0d want=0",
               RdW, ResultW, PendRd);
    end
    checks++;
    if ({q_RegWriteW, q_PendValid, q_LateReady} !== 3'b001) begin
      failures++;
      $display("FAIL reset_flags64 got=%b want=001",
               {q_RegWriteW, q_PendValid, q_LateReady});
    end
    idle();
    rst = 0;
    cyc();
  endtask

  task automatic test_loads32;
    logic [31:0] ad [5];
    logic [2:0]  f3 [5];
    logic [31:0] ex [5];
    ad = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000};
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
    ex = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
           32'h0000_80FF, 32'h80FF_1234};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ValidM = 1; RegWriteM = 1; RdM = 5'd3; ResultSrcM = 2'b01;
      Funct3M = f3[i]; ALUResultM = ad[i]; ReadDataM = 32'h80FF_1234;
      cyc();
      checks++;
      if ({RegWriteW, RdW, ResultW} !== {1'b1, 5'd3, ex[i]}) begin
        failures++;
        $display("FAIL load32_%0d got=%b/%0d/%h want=1/3/%h",
                 i, RegWriteW, RdW, ResultW, ex[i]);
      end
    end
    idle();
  endtask

  task automatic test_loads64;
    logic [63:0] ad [5];
    logic [2:0]  f3 [5];
    logic [63:0] ex [5];
    ad = '{64'h1004, 64'h1004, 64'h1004, 64'h1000, 64'h1007};
    f3 = '{3'b010, 3'b110, 3'b011, 3'b010, 3'b000};
    ex = '{64'hFFFF_FFFF_8000_0001, 64'h0000_0000_8000_0001,
           64'h8000_0001_1234_5678, 64'h0000_0000_1234_5678,
           64'hFFFF_FFFF_FFFF_FF80};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q_ValidM = 1; q_RegWriteM = 1; q_RdM = 5'd4; q_ResultSrcM = 2'b01;
      q_Funct3M = f3[i]; q_ALUResultM = ad[i];
      q_ReadDataM = 64'h8000_0001_1234_5678;
      cyc();
      checks++;
      if ({q_RegWriteW, q_RdW, q_ResultW} !== {1'b1, 5'd4, ex[i]}) begin
        failures++;
        $display("FAIL load64_%0d got=%b/%0d/%h want=1/4/%h",
                 i, q_RegWriteW, q_RdW, q_ResultW, ex[i]);
      end
    end
    idle();
  endtask

  task automatic test_late_collision;
    do_reset();
    LateValid = 1; LateRd = 5'd7; LateData = 32'hDEAD_BEEF;
    issue(5'd5, 32'h55);
    cyc();
    LateValid = 0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if ({RegWriteW, RdW, ResultW, PendValid, PendRd, LateReady} !==
          {1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 1'b0}) begin
        failures++;
        $display("FAIL late_t%0d wr=%b rd=%0d res=%h pv=%b prd=%0d lr=%b",
                 c, RegWriteW, RdW, ResultW, PendValid, PendRd, LateReady);
      end
      if (c == 2) idle();
      cyc();
    end
    checks++;
    if ({RegWriteW, RdW, ResultW, PendRd, LateReady} !==
        {1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 1'b0}) begin
      failures++;
      $display("FAIL late_t3 wr=%b rd=%0d res=%h prd=%0d lr=%b",
               RegWriteW, RdW, ResultW, PendRd, LateReady);
    end
    cyc();
    checks++;
    if ({RegWriteW, PendValid, LateReady} !== 3'b001) begin
      failures++;
      $display("FAIL late_t4 got=%b want=001",
               {RegWriteW, PendValid, LateReady});
    end
  endtask

  task automatic test_stall_flush;
    do_reset();
    issue(5'd9, 32'h1234);
    cyc();
    StallW = 1;
    issue(5'd10, 32'h9999);
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({RegWriteW, RdW, ResultW, InstretW} !==
          {1'b1, 5'd9, 32'h1234, 64'd0}) begin
        failures++;
        $display("FAIL stall_%0d wr=%b rd=%0d res=%h inst=%0d",
                 i, RegWriteW, RdW, ResultW, InstretW);
      end
    end
    idle();
    cyc();
    checks++;
    if ({RegWriteW, InstretW} !== {1'b0, 64'd1}) begin
      failures++;
      $display("FAIL stall_release wr=%b inst=%0d want=0/1",
               RegWriteW, InstretW);
    end
    issue(5'd11, 32'h11);
    cyc();
    StallW = 1; FlushW = 1;
    issue(5'd12, 32'h12);
    cyc();
    checks++;
    if ({RegWriteW, InstretW} !== {1'b0, 64'd1}) begin
      failures++;
      $display("FAIL stall_flush wr=%b inst=%0d want=0/1",
               RegWriteW, InstretW);
    end
    idle();
    cyc();
    checks++;
    if ({RegWriteW, InstretW} !== {1'b0, 64'd1}) begin
      failures++;
      $display("FAIL flush_bubble wr=%b inst=%0d want=0/1",
               RegWriteW, InstretW);
    end
  endtask

  task automatic test_x0;
    do_reset();
    issue(5'd0, 32'hAB);
    cyc();
    idle();
    checks++;
    if (RegWriteW !== 1'b0) begin
      failures++;
      $display("FAIL x0_write got=%b want=0", RegWriteW);
    end
    cyc();
    checks++;
    if (InstretW !== 64'd1) begin
      failures++;
      $display("FAIL x0_instret got=%0d want=1", InstretW);
    end
    LateValid = 1; LateRd = 5'd0; LateData = 32'h77;
    cyc();
    LateValid = 0;
    checks++;
    if ({LateReady, PendValid, RegWriteW} !== 3'b010) begin
      failures++;
      $display("FAIL x0_late_acc got=%b want=010",
               {LateReady, PendValid, RegWriteW});
    end
    cyc();
    checks++;
    if ({LateReady, PendValid, RegWriteW} !== 3'b100) begin
      failures++;
      $display("FAIL x0_late_drop got=%b want=100",
               {LateReady, PendValid, RegWriteW});
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    LateValid = 1; LateRd = 5'd4; LateData = 32'h44;
    issue(5'd6, 32'h66);
    cyc();
    LateValid = 0;
    rst = 1;
    cyc();
    rst = 0;
    idle();
    checks++;
    if ({PendValid, LateReady, RegWriteW, InstretW} !==
        {3'b010, 64'd0}) begin
      failures++;
      $display("FAIL reset_mid pv=%b lr=%b wr=%b inst=%0d",
               PendValid, LateReady, RegWriteW, InstretW);
    end
  endtask

  task automatic test_random;
    logic        wv, wrw, pipe, acc, dr;
    logic [4:0]  wrd;
    logic [31:0] wres, sel;
    logic [37:0] e;
    longint unsigned mi;
    late_t pq[$];
    late_t nl;
    logic [63:0] qe;
    bit          qhave;
    do_reset();
    wv = 0; wrw = 0; wrd = 0; wres = 0; mi = 0; qhave = 0; qe = 0;
    for (int n = 0; n < 400; n++) begin
      if (wrw && wrd != 0) e = {1'b1, wrd, wres};
      else if (pq.size() > 0 && pq[0].rd != 0)
        e = {1'b1, pq[0].rd, pq[0].d};
      else e = {1'b0, wrd, wres};
      checks++;
      if ({RegWriteW, RdW, ResultW} !== e ||
          PendValid !== (pq.size() > 0) ||
          LateReady !== (pq.size() == 0) || InstretW !== mi ||
          (pq.size() > 0 && PendRd !== pq[0].rd)) begin
        failures++;
        $display("FAIL rand_%0d got=%b/%0d/%h pv=%b lr=%b inst=%0d want=%b/%0d/%h pv=%b inst=%0d",
                 n, RegWriteW, RdW, ResultW, PendValid, LateReady,
                 InstretW, e[37], e[36:32], e[31:0], pq.size() > 0, mi);
      end
      if (qhave) begin
        checks++;
        if (q_ResultW !== qe) begin
          failures++;
          $display("FAIL rand64_%0d got=%h want=%h", n, q_ResultW, qe);
        end
      end
      ValidM = ($urandom_range(0, 3) != 0);
      RegWriteM = ($urandom_range(0, 3) != 0);
      ResultSrcM = 2'($urandom); Funct3M = 3'($urandom);
      RdM = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ALUResultM = $urandom; ReadDataM = $urandom;
      PCPlus4M = $urandom; ImmExtM = $urandom;
      StallW = ($urandom_range(0, 4) == 0);
      FlushW = ($urandom_range(0, 9) == 0);
      LateValid = ($urandom_range(0, 2) == 0);
      LateRd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      LateData = $urandom;
      q_ValidM = 1; q_RegWriteM = 1; q_RdM = 5'd1; q_ResultSrcM = 2'b01;
      q_Funct3M = 3'($urandom); q_ALUResultM = {$urandom, $urandom};
      q_ReadDataM = {$urandom, $urandom};
      qe = exp_load(64, q_ALUResultM, q_ReadDataM, q_Funct3M);
      qhave = 1;
      pipe = wrw && wrd != 0;
      acc  = LateValid && pq.size() == 0;
      dr   = !pipe && pq.size() > 0;
      if (dr) void'(pq.pop_front());
      if (acc) begin
        nl.rd = LateRd; nl.d = LateData;
        pq.push_back(nl);
      end
      if (wv && !StallW) mi++;
      case (ResultSrcM)
        2'b00:   sel = ALUResultM;
        2'b01:   sel = 32'(exp_load(32, {32'h0, ALUResultM},
                                    {32'h0, ReadDataM}, Funct3M));
        2'b10:   sel = PCPlus4M;
        default: sel = ImmExtM;
      endcase
      if (FlushW) begin
        wv = 0; wrw = 0; wrd = 0; wres = 0;
      end else if (!StallW) begin
        wv = ValidM; wrw = RegWriteM; wrd = RdM; wres = sel;
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_loads32();
    test_loads64();
    test_late_collision();
    test_stall_flush();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
